// File: rtl/game_pkg.sv
// Screen encodings and widths shared by the game-flow
// controller, the HUD text overlay and the pixel compositor.
package game_pkg;

    typedef enum logic [1:0] {
        SCR_START    = 2'd0,
        SCR_HOWTO    = 2'd1,
        SCR_PLAY     = 2'd2,
        SCR_GAMEOVER = 2'd3
    } screen_t;

    localparam int MAX_LIVES = 3;
    localparam int SCORE_W   = 8;
    localparam int LIVES_W   = $clog2(MAX_LIVES + 1);

endpackage

// File: rtl/btn_conditioner.sv
// Raw button to single-cycle press pulse: 2-flop sync,
// hold-time debounce, registered rising-edge detect.
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;
            // Any return to the accepted level restarts the hold timer
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/game_fsm.sv
// Game-flow controller: screen select state machine plus
// score and lives bookkeeping driven by gameplay pulses.
module game_fsm
    import game_pkg::*;
#(
    parameter int START_LIVES  = 3,
    parameter int GOOD_PTS     = 1,
    parameter int SCORE_MAX    = 255,
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start,
    input  logic               btn_help,
    input  logic               good_evt,
    input  logic               bad_evt,
    output logic [1:0]         screen,
    output logic [SCORE_W-1:0] score_val,
    output logic [LIVES_W-1:0] lives,
    output logic               play_active,
    output logic               game_reset
);

    localparam int SW1 = SCORE_W + 1;

    screen_t          state;
    logic             start_press;
    logic             help_press;
    logic [SW1-1:0]   score_sum;
    logic [SCORE_W-1:0] score_next;

    btn_conditioner #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_start (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_start),
        .press(start_press)
    );

    btn_conditioner #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_help (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_help),
        .press(help_press)
    );

    // Ninth bit keeps the carry so saturation sees true overflow
    assign score_sum  = {1'b0, score_val} + SW1'(GOOD_PTS);
    assign score_next = (score_sum > SW1'(SCORE_MAX))
                      ? SCORE_W'(SCORE_MAX)
                      : score_sum[SCORE_W-1:0];

    assign screen      = state;
    assign play_active = (state == SCR_PLAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SCR_START;
            score_val  <= '0;
            lives      <= LIVES_W'(START_LIVES);
            game_reset <= 1'b0;
        end else begin
            game_reset <= 1'b0;
            unique case (state)
                SCR_START, SCR_HOWTO: begin
                    if (start_press) begin
                        state      <= SCR_PLAY;
                        score_val  <= '0;
                        lives      <= LIVES_W'(START_LIVES);
                        game_reset <= 1'b1;
                    end else if (help_press) begin
                        state <= (state == SCR_START)
                               ? SCR_HOWTO : SCR_START;
                    end
                end
                SCR_PLAY: begin
                    if (good_evt) begin
                        score_val <= score_next;
                    end
                    if (bad_evt && lives != '0) begin
                        lives <= lives - LIVES_W'(1);
                    end
                    if (bad_evt && lives == LIVES_W'(1)) begin
                        state <= SCR_GAMEOVER;
                    end
                end
                SCR_GAMEOVER: begin
                    if (start_press) begin
                        state <= SCR_START;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm: per-cycle model compare
// plus directed literal checks on the main scenarios.
module tb_game_fsm;

    localparam int D    = 4;
    localparam int GP   = 1;
    localparam int SMAX = 255;
    localparam int SL   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_help = 1'b0;
    logic       good_evt = 1'b0;
    logic       bad_evt = 1'b0;
    logic [1:0] screen;
    logic [7:0] score_val;
    logic [1:0] lives;
    logic       play_active;
    logic       game_reset;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model state: screen as 0..3, plain integer score/lives
    int m_scr   = 0;
    int m_score = 0;
    int m_lives = SL;
    int m_gr    = 0;
    int held [2];
    bit acc  [2];
    bit pipe [2][4];

    game_fsm #(
        .START_LIVES (SL),
        .GOOD_PTS    (GP),
        .SCORE_MAX   (SMAX),
        .DEBOUNCE_CYC(D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_start  (btn_start),
        .btn_help   (btn_help),
        .good_evt   (good_evt),
        .bad_evt    (bad_evt),
        .screen     (screen),
        .score_val  (score_val),
        .lives      (lives),
        .play_active(play_active),
        .game_reset (game_reset)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, want);
        end
    endtask

    task automatic model_reset();
        m_scr   = 0;
        m_score = 0;
        m_lives = SL;
        m_gr    = 0;
        for (int b = 0; b < 2; b++) begin
            held[b] = 0;
            acc[b]  = 1'b0;
            for (int k = 0; k < 4; k++) pipe[b][k] = 1'b0;
        end
    endtask

    // A level is accepted after D+1 consecutive differing samples;
    // the FSM acts on that acceptance four clock edges later.
    task automatic model_step();
        bit raw [2];
        bit pr  [2];
        bit now;
        int old_lives;
        raw[0] = btn_start;
        raw[1] = btn_help;
        for (int b = 0; b < 2; b++) begin
            pr[b] = pipe[b][3];
            for (int k = 3; k > 0; k--) pipe[b][k] = pipe[b][k-1];
            now = 1'b0;
            if (raw[b] != acc[b]) begin
                held[b]++;
                if (held[b] == D + 1) begin
                    acc[b]  = raw[b];
                    held[b] = 0;
                    now     = raw[b];
                end
            end else begin
                held[b] = 0;
            end
            pipe[b][0] = now;
        end
        m_gr = 0;
        case (m_scr)
            0, 1: begin
                if (pr[0]) begin
                    m_scr   = 2;
                    m_score = 0;
                    m_lives = SL;
                    m_gr    = 1;
                end else if (pr[1]) begin
                    m_scr = 1 - m_scr;
                end
            end
            2: begin
                old_lives = m_lives;
                if (good_evt) begin
                    m_score = m_score + GP;
                    if (m_score > SMAX) m_score = SMAX;
                end
                if (bad_evt) begin
                    if (m_lives > 0) m_lives = m_lives - 1;
                    if (old_lives == 1) m_scr = 3;
                end
            end
            default: begin
                if (pr[0]) m_scr = 0;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial begin
        wait (started);
        forever begin
            @(negedge clk);
            check("cmp_screen", screen, m_scr);
            check("cmp_score", score_val, m_score);
            check("cmp_lives", lives, m_lives);
            check("cmp_play", play_active, (m_scr == 2) ? 1 : 0);
            check("cmp_greset", game_reset, m_gr);
        end
    end

    task automatic hold_btn(input int b, input int n);
        if (b == 0) btn_start = 1'b1;
        else btn_help = 1'b1;
        repeat (n) @(negedge clk);
        btn_start = 1'b0;
        btn_help  = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse(input bit g, input bit b);
        good_evt = g;
        bad_evt  = b;
        @(negedge clk);
        good_evt = 1'b0;
        bad_evt  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        started = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_screen", screen, 0);
        check("rst_score", score_val, 0);
        check("rst_lives", lives, 3);
        check("rst_play", play_active, 0);
        check("rst_greset", game_reset, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        hold_btn(1, 3);
        check("glitch_screen", screen, 0);
        hold_btn(1, 10);
        check("howto_screen", screen, 1);
        hold_btn(1, 10);
        check("help_back", screen, 0);

        btn_start = 1'b1;
        repeat (8) @(negedge clk);
        check("pre_entry", screen, 0);
        @(negedge clk);
        check("entry_screen", screen, 2);
        check("entry_greset", game_reset, 1);
        check("entry_score", score_val, 0);
        check("entry_lives", lives, 3);
        @(negedge clk);
        check("greset_once", game_reset, 0);
        repeat (10) @(negedge clk);
        btn_start = 1'b0;
        repeat (12) @(negedge clk);
        check("play_hold", screen, 2);

        for (int i = 0; i < 200; i++) pulse(1'b1, 1'b0);
        check("score_200", score_val, 200);
        for (int i = 0; i < 100; i++) pulse(1'b1, 1'b0);
        check("score_sat", score_val, 255);
        check("sat_lives", lives, 3);

        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        check("lives_one", lives, 1);
        check("still_play", screen, 2);
        good_evt = 1'b1;
        bad_evt  = 1'b1;
        @(negedge clk);
        good_evt = 1'b0;
        bad_evt  = 1'b0;
        check("final_lives", lives, 0);
        check("final_score", score_val, 255);
        check("final_screen", screen, 3);
        check("final_play", play_active, 0);
        @(negedge clk);

        hold_btn(0, 10);
        check("over_to_start", screen, 0);
        check("start_keeps", score_val, 255);
        hold_btn(0, 10);
        check("replay_screen", screen, 2);
        check("replay_score", score_val, 0);
        check("replay_lives", lives, 3);

        for (int i = 0; i < 41; i++) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        check("go42_score", score_val, 42);
        check("go42_lives", lives, 0);
        check("go42_screen", screen, 3);

        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        hold_btn(1, 10);
        check("ign_screen", screen, 3);
        check("ign_score", score_val, 42);
        check("ign_lives", lives, 0);

        hold_btn(0, 10);
        check("hold42_screen", screen, 0);
        check("hold42_score", score_val, 42);
        hold_btn(0, 10);
        check("again_screen", screen, 2);
        check("again_score", score_val, 0);
        check("again_lives", lives, 3);

        for (int i = 0; i < 17; i++) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("pre_rst_score", score_val, 17);
        check("pre_rst_lives", lives, 2);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_screen", screen, 0);
        check("mid_rst_score", score_val, 0);
        check("mid_rst_lives", lives, 3);
        check("mid_rst_greset", game_reset, 0);
        repeat (2) @(negedge clk);
        btn_start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("thru_rst_pre", screen, 0);
        @(negedge clk);
        check("thru_rst_play", screen, 2);
        check("thru_rst_gr", game_reset, 1);
        btn_start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
